// File: rtl/flag_ccr_unit.sv
// Condition-code register behind the ALU: masked flag capture, zero-latency
// branch resolution with flag clear, and a shadow stack for interrupt nesting.
module flag_ccr_unit #(
  parameter int DEPTH = 4,
  parameter int PW    = 3
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    flag_we,
  input  logic          alu_z,
  input  logic          alu_n,
  input  logic          alu_c,
  input  logic          alu_v,
  input  logic          br_en,
  input  logic [1:0]    br_cond,
  output logic          br_taken,
  input  logic          int_save,
  input  logic          rti_restore,
  output logic [3:0]    ccr,
  output logic          carry_q,
  output logic [PW-1:0] stk_depth,
  output logic [1:0]    stk_err
);

  logic [3:0]    ccr_r;
  logic [3:0]    stack_r [DEPTH];
  logic [PW-1:0] depth_r;
  logic [1:0]    err_r;

  logic [3:0]    alu_flags_s;
  logic [3:0]    merged_s;
  logic [3:0]    step3_s;
  logic [3:0]    top_s;
  logic [3:0]    ccr_nxt_s;
  logic [PW-1:0] depth_nxt_s;
  logic [1:0]    err_nxt_s;
  logic          br_taken_s;
  logic          full_s;
  logic          empty_s;
  logic          pop_ok_s;
  logic          push_ok_s;

  // One-hot mask selecting the flag tested by a branch condition.
  function automatic logic [3:0] cond_mask(input logic [1:0] cond);
    logic [3:0] m;
    case (cond)
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0010;
      2'b10:   m = 4'b0100;
      2'b11:   m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  assign alu_flags_s = {alu_v, alu_c, alu_n, alu_z};
  assign full_s      = (depth_r == PW'(DEPTH));
  assign empty_s     = (depth_r == {PW{1'b0}});
  // A simultaneous save is always dropped in favour of the restore.
  assign pop_ok_s    = rti_restore & ~empty_s;
  assign push_ok_s   = int_save & ~rti_restore & ~full_s;

  // Bypassed flags, branch decision and post-branch flag value.
  always_comb begin
    merged_s   = (flag_we & alu_flags_s) | (~flag_we & ccr_r);
    br_taken_s = br_en & |(merged_s & cond_mask(br_cond));
    if (br_taken_s) begin
      step3_s = merged_s & ~cond_mask(br_cond);
    end else begin
      step3_s = merged_s;
    end
  end

  // Top-of-stack read: entry depth-1.
  always_comb begin
    top_s = 4'b0000;
    for (int i = 0; i < DEPTH; i++) begin
      top_s = (depth_r == PW'(i + 1)) ? stack_r[i] : top_s;
    end
  end

  // Next CCR, stack depth and sticky error flags.
  always_comb begin
    ccr_nxt_s   = step3_s;
    depth_nxt_s = depth_r;
    err_nxt_s   = err_r;
    if (pop_ok_s) begin
      ccr_nxt_s   = top_s;
      depth_nxt_s = depth_r - PW'(1);
    end else if (push_ok_s) begin
      depth_nxt_s = depth_r + PW'(1);
    end else begin
      depth_nxt_s = depth_r;
    end
    err_nxt_s[0] = err_r[0] | (int_save & (rti_restore | full_s));
    err_nxt_s[1] = err_r[1] | (rti_restore & empty_s);
  end

  // State registers; the push writes the slot just above the current top.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ccr_r   <= 4'b0000;
      depth_r <= {PW{1'b0}};
      err_r   <= 2'b00;
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= 4'b0000;
      end
    end else begin
      ccr_r   <= ccr_nxt_s;
      depth_r <= depth_nxt_s;
      err_r   <= err_nxt_s;
      for (int i = 0; i < DEPTH; i++) begin
        if (push_ok_s && (depth_r == PW'(i))) begin
          stack_r[i] <= step3_s;
        end
      end
    end
  end

  assign br_taken  = br_taken_s;
  assign ccr       = ccr_r;
  assign carry_q   = ccr_r[2];
  assign stk_depth = depth_r;
  assign stk_err   = err_r;

endmodule
